pipeline_hazard_controller: RTL

- Central stall/flush sequencer for the 5-stage MIPS pipeline.
- Combines three stall and flush sources into the PC, IF/ID and ID/EX control signals:
  - load-use hazard detection;
  - branch/jump flush from EX;
  - scheduling of the shared iterative multiply/divide unit and its HI/LO write-back.
- Sits beside the ID stage.
- Owns the only state machine that decides when MULT/DIV may issue and when MFHI/MFLO may proceed.

---
 rtl/pipeline_hazard_controller.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/pipeline_hazard_controller.sv
// Stall/flush sequencer for the 5-stage MIPS pipeline: load-use detection,
// EX-resolved branch flush, and issue/write-back scheduling of the shared mult/div unit.
module pipeline_hazard_controller #(
    parameter int MULT_CYCLES = 4,
    parameter int DIV_CYCLES  = 32,
    parameter int CNT_W       = 6
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] Id_Ex_MemRead,
    input  logic [4:0] Id_Ex_rt,
    input  logic [4:0] If_Id_rs,
    input  logic [4:0] If_Id_rt,
    input  logic       id_is_mult,
    input  logic       id_is_div,
    input  logic       id_reads_hilo,
    input  logic       ex_flush,
    output logic       PCWrite,
    output logic       If_Id_Write,
    output logic       If_Id_Flush,
    output logic       Stall,
    output logic       md_start,
    output logic       md_op,
    output logic       md_busy,
    output logic       hilo_write
);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        MD_RUN = 2'b01,
        MD_WB  = 2'b10
    } state_t;

    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    state_t           state_r;
    state_t           state_nxt_s;
    logic [CNT_W-1:0] count_r;
    logic [CNT_W-1:0] count_nxt_s;

    logic load_hz_s;
    logic md_hz_s;
    logic hz_s;
    logic md_req_s;
    logic issue_s;
    logic run_done_s;

    logic md_start_r;
    logic md_op_r;
    logic hilo_write_r;

    // Register 0 is deliberately not special-cased: a load to $zero still stalls.
    assign load_hz_s  = (Id_Ex_MemRead != 2'b00) &&
                        ((Id_Ex_rt == If_Id_rs) || (Id_Ex_rt == If_Id_rt));
    assign md_hz_s    = (state_r != IDLE) && (id_is_mult || id_is_div || id_reads_hilo);
    assign hz_s       = load_hz_s || md_hz_s;
    assign md_req_s   = id_is_mult || id_is_div;
    assign issue_s    = (state_r == IDLE) && md_req_s && !hz_s && !ex_flush;
    assign run_done_s = (state_r == MD_RUN) && (count_r == CNT_ZERO);

    // State and busy-counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            count_r <= CNT_ZERO;
        end else begin
            state_r <= state_nxt_s;
            count_r <= count_nxt_s;
        end
    end

    // Next-state and counter logic; divide wins when both requests are set.
    always_comb begin
        state_nxt_s = state_r;
        count_nxt_s = count_r;
        case (state_r)
            IDLE: begin
                if (issue_s) begin
                    state_nxt_s = MD_RUN;
                    count_nxt_s = id_is_div ? DIV_LOAD : MULT_LOAD;
                end else begin
                    state_nxt_s = IDLE;
                    count_nxt_s = count_r;
                end
            end
            MD_RUN: begin
                if (count_r == CNT_ZERO) begin
                    state_nxt_s = MD_WB;
                    count_nxt_s = CNT_ZERO;
                end else begin
                    state_nxt_s = MD_RUN;
                    count_nxt_s = count_r - CNT_ONE;
                end
            end
            MD_WB: begin
                state_nxt_s = IDLE;
                count_nxt_s = CNT_ZERO;
            end
            default: begin
                state_nxt_s = IDLE;
                count_nxt_s = CNT_ZERO;
            end
        endcase
    end

    // Pipeline enables; a flush squashes the wrong-path ID instruction even while hazards are present.
    always_comb begin
        PCWrite     = 1'b1;
        If_Id_Write = 1'b1;
        If_Id_Flush = 1'b0;
        Stall       = 1'b0;
        if (ex_flush) begin
            PCWrite     = 1'b1;
            If_Id_Write = 1'b1;
            If_Id_Flush = 1'b1;
            Stall       = 1'b1;
        end else if (hz_s) begin
            PCWrite     = 1'b0;
            If_Id_Write = 1'b0;
            If_Id_Flush = 1'b0;
            Stall       = 1'b1;
        end else begin
            PCWrite     = 1'b1;
            If_Id_Write = 1'b1;
            If_Id_Flush = 1'b0;
            Stall       = 1'b0;
        end
    end

    // Registered mult/div handshake: start pulse, held opcode, one-cycle HI/LO write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            md_start_r   <= 1'b0;
            md_op_r      <= 1'b0;
            hilo_write_r <= 1'b0;
        end else begin
            md_start_r   <= issue_s;
            md_op_r      <= issue_s ? id_is_div : md_op_r;
            hilo_write_r <= run_done_s;
        end
    end

    assign md_start   = md_start_r;
    assign md_op      = md_op_r;
    assign hilo_write = hilo_write_r;
    assign md_busy    = (state_r != IDLE);

endmodule
